hazard_stall_unit: RTL

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

---
 rtl/hazard_stall_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Pipeline hazard controller: resolves taken-branch flushes, holds EX for
// multi-cycle fdiv/fsqrt operations, stalls one cycle on load-use hazards
// and keeps a saturating count of stall cycles.

module hazard_stall_unit #(
    parameter int FDIV_LAT  = 16,
    parameter int FSQRT_LAT = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ID_Rs1,
    input  logic [4:0]  ID_Rs2,
    input  logic [4:0]  ID_frs3,
    input  logic        ID_Valid,
    input  logic [4:0]  EX_Rd,
    input  logic        EX_MemRead,
    input  logic        EX_f_MemRead,
    input  logic        EX_LongOp,
    input  logic        EX_LongSel,
    input  logic        EX_BranchTaken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        EX_Hold,
    output logic        FPU_Start,
    output logic        FPU_Busy,
    output logic [15:0] StallCount
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The start cycle and the final release cycle are not counted in cnt,
    // so BUSY begins with LAT-2 remaining hold cycles.
    localparam logic [4:0] FDIV_CNT_INIT  = 5'(FDIV_LAT - 2);
    localparam logic [4:0] FSQRT_CNT_INIT = 5'(FSQRT_LAT - 2);

    state_t      state;
    state_t      next_state;
    logic [4:0]  cnt;
    logic [4:0]  next_cnt;
    logic        int_load_use;
    logic        fp_load_use;
    logic        load_use;

    // Load-use detection: x0 never creates a hazard, f0 is a real FP register
    always_comb begin
        int_load_use = EX_MemRead && (EX_Rd != 5'd0) &&
                       ((EX_Rd == ID_Rs1) || (EX_Rd == ID_Rs2));
        fp_load_use  = EX_f_MemRead &&
                       ((EX_Rd == ID_Rs1) || (EX_Rd == ID_Rs2) || (EX_Rd == ID_frs3));
        load_use     = ID_Valid && (int_load_use || fp_load_use);
    end

    // Next-state and output decode: branch beats long-op beats load-use in IDLE
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        EX_Hold     = 1'b0;
        FPU_Start   = 1'b0;
        FPU_Busy    = 1'b0;

        unique case (state)
            IDLE: begin
                if (EX_BranchTaken) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (EX_LongOp) begin
                    FPU_Start   = 1'b1;
                    EX_Hold     = 1'b1;
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    next_state  = BUSY;
                    next_cnt    = EX_LongSel ? FSQRT_CNT_INIT : FDIV_CNT_INIT;
                end else if (load_use) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end

            BUSY: begin
                FPU_Busy = 1'b1;
                if (cnt != 5'd0) begin
                    EX_Hold     = 1'b1;
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    next_cnt    = cnt - 5'd1;
                end else begin
                    next_state  = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
                next_cnt   = 5'd0;
            end
        endcase
    end

    // State and occupancy counter; reset abandons any in-flight long op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Saturating stall-cycle counter, stepped whenever the PC is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= 16'd0;
        end else if (!PCWrite && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end

endmodule
